// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types, constants and the CGA 16-colour palette
//                function for the VGA pixel renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int PIPE_DEPTH           = 3;
    localparam int CURSOR_BLINK_BIT_DEF = 3;
    localparam int CHAR_BLINK_BIT_DEF   = 4;
    localparam int FRAME_CNT_W          = 5;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // CGA colour: each set primary bit gives 0xA, the intensity bit adds 0x5.
    // Colour 6 is the odd one out: its green is pulled down to make brown.
    function automatic rgb_t cga_to_rgb(input logic [3:0] c);
        rgb_t       rgb;
        logic [3:0] lift;
        lift  = c[3] ? 4'h5 : 4'h0;
        rgb.r = (c[2] ? 4'hA : 4'h0) + lift;
        rgb.g = (c[1] ? 4'hA : 4'h0) + lift;
        rgb.b = (c[0] ? 4'hA : 4'h0) + lift;
        if (c == 4'd6) begin
            rgb.g = 4'h5;
        end
        return rgb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_renderer_if
//  Description : Frame-buffer cell outputs and font ROM port seen by the
//                pixel renderer. The renderer is the slave of the frame
//                buffer cell data and the address master of the font ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_pixel_renderer_if;

    logic [7:0]  glyph;
    logic [3:0]  foreground;
    logic [3:0]  background;
    logic        render_cursor;
    logic [1:0]  graphics_colour;
    logic [10:0] font_addr;
    logic [7:0]  font_data;

    modport master (
        output glyph, foreground, background, render_cursor, graphics_colour,
        output font_data,
        input  font_addr
    );

    modport slave (
        input  glyph, foreground, background, render_cursor, graphics_colour,
        input  font_data,
        output font_addr
    );

endinterface
`default_nettype wire

// File: rtl/vga_palette.sv
`default_nettype none
// ============================================================================
//  Module      : vga_palette
//  Description : Combinational CGA 4-bit colour index to 4:4:4 RGB.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_palette
    import vga_pkg::*;
(
    input  wire logic [3:0] idx_i,
    output rgb_t            rgb_o
);

    assign rgb_o = cga_to_rgb(idx_i);

endmodule
`default_nettype wire

// File: rtl/vga_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_renderer
//  Description : Three-stage pipeline turning frame-buffer text cells or
//                2-bit graphics pixels into CGA-palette RGB, with glyph
//                lookup in an external font ROM, cursor/character blink
//                and sync delay matched to the RGB path.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_renderer
    import vga_pkg::*;
#(
    parameter int CURSOR_BLINK_BIT = CURSOR_BLINK_BIT_DEF,
    parameter int CHAR_BLINK_BIT   = CHAR_BLINK_BIT_DEF
)(
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic [9:0]  row,
    input  wire logic [9:0]  col,
    input  wire logic        is_blank,
    input  wire logic        hsync_in,
    input  wire logic        vsync_in,
    input  wire logic        graphics_enabled,
    input  wire logic        blink_enable,
    input  wire logic        cga_palette_sel,
    input  wire logic        cga_intensity,
    input  wire logic [3:0]  cga_bg_colour,
    vga_pixel_renderer_if.slave fb,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hsync,
    output logic             vga_vsync
);

    // Only the glyph-row and in-cell column bits matter to this block.
    wire logic unused_bits = ^{row[9:4], row[0], col[9:3]};

    // Stage 1: raw scan position, blank, syncs and mode
    logic [2:0] s1_row_q, s1_col_q;
    logic       s1_blank_q, s1_hs_q, s1_vs_q, s1_gfx_q;

    // Stage 2: resolved cell colours and blink/cursor decisions
    logic [2:0] s2_col_q;
    logic       s2_blank_q, s2_hs_q, s2_vs_q, s2_gfx_q;
    logic [3:0] s2_fg_q, s2_bg_idx_q, s2_gfx_idx_q;
    logic       s2_cursor_q, s2_hide_q;
    logic [3:0] s2_bg_idx_d, s2_gfx_idx_d;
    logic       s2_cursor_d, s2_hide_d, s2_blink_d;

    // Stage 3: output register
    rgb_t       rgb_q, rgb_d, pal_rgb;
    logic       hs_q, vs_q;
    logic [3:0] pix_idx;
    logic       pix_bit;

    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // The font ROM registers this address itself, so it is driven straight
    // from the stage-1 row alongside the glyph arriving this cycle.
    assign fb.font_addr = {fb.glyph, s1_row_q};

    // Frame counter steps on a vsync rising edge seen against the stage-1 copy
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (vsync_in && !s1_vs_q) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Cell attribute decode feeding stage 2
    always_comb begin
        s2_blink_d  = blink_enable && fb.background[3];
        s2_bg_idx_d = s2_blink_d ? {1'b0, fb.background[2:0]} : fb.background;
        s2_hide_d   = s2_blink_d && !frame_cnt_q[CHAR_BLINK_BIT];
        s2_cursor_d = fb.render_cursor && frame_cnt_q[CURSOR_BLINK_BIT];
        // {k, sel} is 2k+sel, giving colours 2/4/6 or 3/5/7
        s2_gfx_idx_d = {cga_intensity, fb.graphics_colour, cga_palette_sel};
        if (fb.graphics_colour == 2'd0) begin
            s2_gfx_idx_d = cga_bg_colour;
        end
    end

    // Pixel colour selection; cursor overrides the character-blink hide
    always_comb begin
        pix_bit = fb.font_data[3'd7 - s2_col_q];
        pix_idx = s2_bg_idx_q;
        if (s2_gfx_q) begin
            pix_idx = s2_gfx_idx_q;
        end else if (s2_cursor_q || (pix_bit && !s2_hide_q)) begin
            pix_idx = s2_fg_q;
        end
        rgb_d = s2_blank_q ? '0 : pal_rgb;
    end

    vga_palette u_palette (
        .idx_i (pix_idx),
        .rgb_o (pal_rgb)
    );

    // Pipeline registers and frame counter, cleared together on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            s1_blank_q   <= 1'b0;
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
            s1_gfx_q     <= 1'b0;
            s2_col_q     <= '0;
            s2_blank_q   <= 1'b0;
            s2_hs_q      <= 1'b0;
            s2_vs_q      <= 1'b0;
            s2_gfx_q     <= 1'b0;
            s2_fg_q      <= '0;
            s2_bg_idx_q  <= '0;
            s2_gfx_idx_q <= '0;
            s2_cursor_q  <= 1'b0;
            s2_hide_q    <= 1'b0;
            rgb_q        <= '0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            s1_row_q     <= row[3:1];
            s1_col_q     <= col[2:0];
            s1_blank_q   <= is_blank;
            s1_hs_q      <= hsync_in;
            s1_vs_q      <= vsync_in;
            s1_gfx_q     <= graphics_enabled;
            s2_col_q     <= s1_col_q;
            s2_blank_q   <= s1_blank_q;
            s2_hs_q      <= s1_hs_q;
            s2_vs_q      <= s1_vs_q;
            s2_gfx_q     <= s1_gfx_q;
            s2_fg_q      <= fb.foreground;
            s2_bg_idx_q  <= s2_bg_idx_d;
            s2_gfx_idx_q <= s2_gfx_idx_d;
            s2_cursor_q  <= s2_cursor_d;
            s2_hide_q    <= s2_hide_d;
            rgb_q        <= rgb_d;
            hs_q         <= s2_hs_q;
            vs_q         <= s2_vs_q;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign vga_r     = rgb_q.r;
    assign vga_g     = rgb_q.g;
    assign vga_b     = rgb_q.b;
    assign vga_hsync = hs_q;
    assign vga_vsync = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_renderer
//  Description : Randomised and directed bench for vga_pixel_renderer with
//                a cycle-history reference model and a font ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_renderer;

    localparam int MAXC     = 2048;
    localparam int CUR_BIT  = 3;
    localparam int CHAR_BIT = 4;

    typedef struct packed {
        logic       rst_n;
        logic [9:0] row;
        logic [9:0] col;
        logic       blank, hs, vs, gfx;
        logic [7:0] glyph;
        logic [3:0] fg, bg;
        logic       cur;
        logic [1:0] gc;
        logic       be, sel, inten;
        logic [3:0] cbg;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] row, col;
    logic       is_blank, hsync_in, vsync_in, graphics_enabled;
    logic       blink_enable, cga_palette_sel, cga_intensity;
    logic [3:0] cga_bg_colour;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hsync, vga_vsync;

    vga_pixel_renderer_if fb();

    vga_pixel_renderer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .row              (row),
        .col              (col),
        .is_blank         (is_blank),
        .hsync_in         (hsync_in),
        .vsync_in         (vsync_in),
        .graphics_enabled (graphics_enabled),
        .blink_enable     (blink_enable),
        .cga_palette_sel  (cga_palette_sel),
        .cga_intensity    (cga_intensity),
        .cga_bg_colour    (cga_bg_colour),
        .fb               (fb),
        .vga_r            (vga_r),
        .vga_g            (vga_g),
        .vga_b            (vga_b),
        .vga_hsync        (vga_hsync),
        .vga_vsync        (vga_vsync)
    );

    always #5 clk = ~clk;

    // Font ROM with one cycle of read latency
    logic [7:0] font_mem [2048];
    always @(posedge clk) fb.font_data <= font_mem[fb.font_addr];

    // CGA palette written out as the colour table
    logic [11:0] pal_tab [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA,
                                  12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                                  12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                                  12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    cyc_t        h       [MAXC];
    int          rel_at  [MAXC];
    logic [4:0]  fcnt    [MAXC];
    logic        lit_v   [MAXC];
    logic [12:0] lit_val [MAXC];

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic running = 1'b1;
    logic want_rst_n = 1'b0;

    // Directed/random stimulus for the current pixel, and the frame-buffer
    // side values held back one cycle to arrive at N+1.
    logic [9:0] d_row, d_col;
    logic       d_blank, d_hs, d_vs, d_gfx, d_cur, d_be, d_sel, d_inten;
    logic [7:0] d_glyph, p_glyph;
    logic [3:0] d_fg, d_bg, d_cbg, p_fg, p_bg, p_cbg;
    logic [1:0] d_gc, p_gc;
    logic       p_cur, p_be, p_sel, p_inten;

    task automatic cmp(input string nm, input logic [12:0] act, input logic [12:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int n);
        cyc_t       p, q;
        logic [4:0] fc;
        logic [3:0] ci, bgi;
        logic [7:0] fbyte;
        logic [2:0] bi;
        logic       bitv, blinking;
        p  = h[n];
        q  = h[n+1];
        fc = fcnt[n];
        if (p.blank) return 12'h000;
        if (p.gfx) begin
            if (q.gc == 2'd0) ci = q.cbg;
            else ci = {q.inten, 3'(2 * int'(q.gc) + int'(q.sel))};
        end else begin
            fbyte    = font_mem[{q.glyph, p.row[3:1]}];
            bi       = 3'd7 - p.col[2:0];
            bitv     = fbyte[bi];
            blinking = q.be && q.bg[3];
            bgi      = blinking ? {1'b0, q.bg[2:0]} : q.bg;
            if (blinking && !fc[CHAR_BIT]) bitv = 1'b0;
            if (q.cur && fc[CUR_BIT]) bitv = 1'b1;
            ci = bitv ? q.fg : bgi;
        end
        return pal_tab[ci];
    endfunction

    task automatic check_cycle(input int t);
        logic [11:0] act;
        int          t0, n;
        act = {vga_r, vga_g, vga_b};
        if (!h[t].rst_n) begin
            cmp("reset_rgb", {1'b0, act}, 13'h0);
            cmp("reset_sync", {11'h0, vga_hsync, vga_vsync}, 13'h0);
        end else begin
            t0 = rel_at[t];
            n  = t - 3;
            if (n < t0) begin
                cmp("post_reset_sync", {11'h0, vga_hsync, vga_vsync}, 13'h0);
                if (t < t0 + 2) cmp("post_reset_rgb", {1'b0, act}, 13'h0);
            end else begin
                cmp("rgb", {1'b0, act}, {1'b0, model_rgb(n)});
                cmp("sync", {11'h0, vga_hsync, vga_vsync}, {11'h0, h[n].hs, h[n].vs});
            end
            if (t > t0) cmp("font_addr", {2'b0, fb.font_addr}, {2'b0, h[t].glyph, h[t-1].row[3:1]});
        end
        if (lit_v[t]) cmp("literal_hs_rgb", {vga_hsync, act}, lit_val[t]);
    endtask

    always @(negedge clk) begin
        if (running && cyc >= 1) check_cycle(cyc);
    end

    task automatic dstep(input logic len, input logic [12:0] lit);
        cyc_t e;
        @(posedge clk);
        #1;
        cyc++;
        reset_n          = want_rst_n;
        row              = d_row;
        col              = d_col;
        is_blank         = d_blank;
        hsync_in         = d_hs;
        vsync_in         = d_vs;
        graphics_enabled = d_gfx;
        fb.glyph           = p_glyph;
        fb.foreground      = p_fg;
        fb.background      = p_bg;
        fb.render_cursor   = p_cur;
        fb.graphics_colour = p_gc;
        blink_enable       = p_be;
        cga_palette_sel    = p_sel;
        cga_intensity      = p_inten;
        cga_bg_colour      = p_cbg;
        p_glyph = d_glyph; p_fg = d_fg; p_bg = d_bg; p_cur = d_cur; p_gc = d_gc;
        p_be = d_be; p_sel = d_sel; p_inten = d_inten; p_cbg = d_cbg;
        e.rst_n = reset_n; e.row = row; e.col = col; e.blank = is_blank;
        e.hs = hsync_in; e.vs = vsync_in; e.gfx = graphics_enabled;
        e.glyph = fb.glyph; e.fg = fb.foreground; e.bg = fb.background;
        e.cur = fb.render_cursor; e.gc = fb.graphics_colour; e.be = blink_enable;
        e.sel = cga_palette_sel; e.inten = cga_intensity; e.cbg = cga_bg_colour;
        h[cyc] = e;
        rel_at[cyc] = (reset_n && !h[cyc-1].rst_n) ? cyc : rel_at[cyc-1];
        if (!reset_n) fcnt[cyc] = 5'd0;
        else if (cyc == rel_at[cyc]) fcnt[cyc] = vsync_in ? 5'd1 : 5'd0;
        else fcnt[cyc] = fcnt[cyc-1] + ((vsync_in && !h[cyc-1].vs) ? 5'd1 : 5'd0);
        if (len) begin
            lit_v[cyc+3]   = 1'b1;
            lit_val[cyc+3] = lit;
        end
    endtask

    task automatic rstep();
        d_row   = 10'($urandom_range(0, 1023));
        d_col   = 10'($urandom_range(0, 1023));
        d_blank = ($urandom_range(0, 7) == 0);
        d_hs    = ($urandom_range(0, 9) == 0);
        d_vs    = ($urandom_range(0, 3) == 0);
        d_gfx   = ($urandom_range(0, 3) == 0);
        d_glyph = 8'($urandom);
        d_fg    = 4'($urandom);
        d_bg    = 4'($urandom);
        d_cur   = 1'($urandom);
        d_gc    = 2'($urandom);
        d_be    = 1'($urandom);
        d_sel   = 1'($urandom);
        d_inten = 1'($urandom);
        d_cbg   = 4'($urandom);
        dstep(1'b0, 13'h0);
    endtask

    task automatic dset_idle();
        d_row = 10'd6; d_col = 10'd80; d_blank = 1'b1; d_hs = 1'b0; d_vs = 1'b0;
        d_gfx = 1'b0; d_glyph = 8'h41; d_fg = 4'hF; d_bg = 4'h1; d_cur = 1'b0;
        d_gc = 2'd0; d_be = 1'b0; d_sel = 1'b0; d_inten = 1'b0; d_cbg = 4'h0;
    endtask

    // One text cell row: literal pattern is 'on' at columns 0 and 7 only
    task automatic cell_row(input logic [11:0] on_c, input logic [11:0] off_c);
        d_blank = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d_col = 10'(80 + i);
            dstep(1'b1, {1'b0, (i == 0 || i == 7) ? on_c : off_c});
        end
        d_blank = 1'b1;
        dstep(1'b0, 13'h0);
    endtask

    task automatic vs_pulses(input int k);
        d_blank = 1'b1; d_cur = 1'b0;
        for (int i = 0; i < k; i++) begin
            d_vs = 1'b1; dstep(1'b0, 13'h0);
            d_vs = 1'b0; dstep(1'b0, 13'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) font_mem[i] = 8'($urandom);
        font_mem[{8'h41, 3'd3}] = 8'h81;
        for (int i = 0; i < MAXC; i++) begin lit_v[i] = 1'b0; lit_val[i] = 13'h0; end
        h[0] = '0; rel_at[0] = 0; fcnt[0] = 5'd0;
        reset_n = 1'b0; row = '0; col = '0; is_blank = 1'b0; hsync_in = 1'b0;
        vsync_in = 1'b0; graphics_enabled = 1'b0; blink_enable = 1'b0;
        cga_palette_sel = 1'b0; cga_intensity = 1'b0; cga_bg_colour = '0;
        fb.glyph = '0; fb.foreground = '0; fb.background = '0;
        fb.render_cursor = 1'b0; fb.graphics_colour = '0;
        p_glyph = '0; p_fg = '0; p_bg = '0; p_cur = 1'b0; p_gc = '0;
        p_be = 1'b0; p_sel = 1'b0; p_inten = 1'b0; p_cbg = '0;

        // Reset with random inputs, then random traffic
        want_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) rstep();
        want_rst_n = 1'b1;
        for (int i = 0; i < 400; i++) rstep();

        // Fresh reset so the frame counter starts from zero for directed cases
        dset_idle();
        want_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) dstep(1'b0, 13'h0);
        want_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) dstep(1'b0, 13'h0);

        // Glyph 0x81, fg=F bg=1
        cell_row(12'hFFF, 12'h00A);

        // Character blink: hidden at frame 0, shown at frame 16
        d_be = 1'b1; d_bg = 4'h9; d_fg = 4'hE;
        cell_row(12'h00A, 12'h00A);
        vs_pulses(16);
        cell_row(12'hFF5, 12'h00A);

        // Cursor: frame 24 shows it, frame 32 (wrapped to 0) hides it
        d_be = 1'b0; d_bg = 4'h1; d_fg = 4'hE;
        vs_pulses(8);
        d_cur = 1'b1;
        cell_row(12'hFF5, 12'hFF5);
        vs_pulses(8);
        d_cur = 1'b1;
        cell_row(12'hFF5, 12'h00A);
        d_cur = 1'b0;

        // Graphics palette 1 with intensity, then index 0 as brown
        d_blank = 1'b0; d_gfx = 1'b1; d_sel = 1'b1; d_inten = 1'b1; d_cbg = 4'h6;
        d_gc = 2'd1; dstep(1'b1, {1'b0, 12'h5FF});
        d_gc = 2'd2; dstep(1'b1, {1'b0, 12'hF5F});
        d_gc = 2'd3; dstep(1'b1, {1'b0, 12'hFFF});
        d_gc = 2'd0; dstep(1'b1, {1'b0, 12'hA50});

        // Blanking beats the cursor and foreground
        d_gfx = 1'b0; d_fg = 4'hF; d_cur = 1'b1; d_blank = 1'b1;
        dstep(1'b1, 13'h0);
        dstep(1'b1, 13'h0);

        // Two-cycle hsync pulse emerges three cycles later, same width
        d_cur = 1'b0;
        d_hs = 1'b0; dstep(1'b1, 13'h0000);
        d_hs = 1'b1; dstep(1'b1, 13'h1000);
        d_hs = 1'b1; dstep(1'b1, 13'h1000);
        d_hs = 1'b0; dstep(1'b1, 13'h0000);
        dstep(1'b1, 13'h0000);

        // Random traffic with a reset dropped in mid-stream
        for (int i = 0; i < 200; i++) rstep();
        want_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) rstep();
        want_rst_n = 1'b1;
        for (int i = 0; i < 300; i++) rstep();
        for (int i = 0; i < 4; i++) rstep();

        @(posedge clk);
        running = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
